// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Requests are accepted in IDLE, the ALU is driven from registers for one
// EXEC cycle, and the result is held in the owner's response slot until the
// owner takes it.

// One response slot: captures the ALU outputs and holds them until taken.
module alu_share_resp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] res_in,
    input  logic             zero_in,
    input  logic             ovf_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic             done
);

    assign done = valid & ready;

    // Capture the result on EXEC and hold it until the handshake. The payload
    // is left in place after release and only changes on the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            res   <= '0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            res   <= res_in;
            zero  <= zero_in;
            ovf   <= ovf_in;
        end else if (done) begin
            valid <= 1'b0;
        end
    end

endmodule

module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_res,
    output logic             resp0_zero,
    output logic             resp0_ovf,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_res,
    output logic             resp1_zero,
    output logic             resp1_ovf,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                             last_grant;
    logic                             owner;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0][2:0]          req_op;
    logic [NUM_REQ-1:0][WIDTH-1:0]    req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0]    req_b;
    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             accept;
    logic                             sel;
    logic [NUM_REQ-1:0]               slot_ready;
    logic [NUM_REQ-1:0]               slot_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0]    slot_res;
    logic [NUM_REQ-1:0]               slot_zero;
    logic [NUM_REQ-1:0]               slot_ovf;
    logic [NUM_REQ-1:0]               slot_done;
    logic                             resp_done;

    assign req_valid = {req1_valid, req0_valid};
    assign req_op    = {req1_op, req0_op};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign slot_ready = {resp1_ready, resp0_ready};

    // Round-robin grant: a lone requester wins; on a tie the one that was not
    // served last wins. last_grant resets to 1 so requester 0 takes the first tie.
    always_comb begin
        grant = '0;
        if (req_valid[0] && (!req_valid[1] || last_grant)) begin
            grant[0] = 1'b1;
        end else if (req_valid[1]) begin
            grant[1] = 1'b1;
        end
    end

    assign req_ready  = (state == S_IDLE) ? grant : '0;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |req_ready;
    assign sel        = req_ready[1];
    assign resp_done  = (state == S_RESP) && slot_done[owner];
    assign busy       = (state != S_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, one EXEC cycle, wait for the owner's take in RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = S_EXEC;
            S_EXEC:                 state_nxt = S_RESP;
            S_RESP:  if (resp_done) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // ALU drive registers and ownership; only written on the request handshake,
    // so the ALU inputs hold steady outside EXEC and ignore later input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_op     <= req_op[sel];
            alu_a      <= req_a[sel];
            alu_b      <= req_b[sel];
            owner      <= sel;
            last_grant <= sel;
        end
    end

    // Completed-operation counter, advanced on the response handshake; wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (resp_done) begin
            op_count <= op_count + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        alu_share_resp_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .capture ((state == S_EXEC) && (owner == 1'(g))),
            .res_in  (alu_res),
            .zero_in (alu_zero),
            .ovf_in  (alu_ovf),
            .ready   (slot_ready[g]),
            .valid   (slot_valid[g]),
            .res     (slot_res[g]),
            .zero    (slot_zero[g]),
            .ovf     (slot_ovf[g]),
            .done    (slot_done[g])
        );
    end

    assign resp0_valid = slot_valid[0];
    assign resp0_res   = slot_res[0];
    assign resp0_zero  = slot_zero[0];
    assign resp0_ovf   = slot_ovf[0];
    assign resp1_valid = slot_valid[1];
    assign resp1_res   = slot_res[1];
    assign resp1_zero  = slot_zero[1];
    assign resp1_ovf   = slot_ovf[1];

endmodule
